arp_responder_mc: RTL and testbench

Parametrised ARP engine for the Ethernet receive path. It answers ARP requests for up to N_IP local IPv4 addresses and queues replies so back-to-back requests are not lost. It validates the full ARP header and reports learned sender bindings from incoming ARP replies. It runs in a single clock domain and sits between the ethertype demux (0x0806 payload) and the tx arbiter.

---
 rtl/arp_pkg.sv | 34 +++
 rtl/arp_reply_queue.sv | 74 +++++++
 rtl/arp_responder_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_arp_responder_mc.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, rx state encoding and reply-queue entry type.
package arp_pkg;

    localparam logic [15:0] ARP_ETHERTYPE   = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY  = 16'd2;
    localparam int          ARP_RX_LEN      = 28;
    localparam int          ARP_TX_LEN      = 30;
    localparam int          ARP_TX_LEN_PAD  = 48;

    // Fixed leading ten bytes of every reply frame
    localparam logic [79:0] ARP_REPLY_HDR = {
        ARP_ETHERTYPE, ARP_HTYPE_ETH, ARP_PTYPE_IPV4,
        ARP_HLEN, ARP_PLEN, ARP_OPER_REPLY
    };

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HDR,
        RX_DONE,
        RX_ERR
    } rx_state_e;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [1:0]  idx;
    } arp_entry_t;

endpackage

// File: rtl/arp_reply_queue.sv
// Pending-reply FIFO; push is ignored when full, pop is ignored when empty.
module arp_reply_queue
    import arp_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic       rx_clock,
    input  logic       reset,
    input  logic       push,
    input  arp_entry_t push_entry,
    input  logic       pop,
    output arp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

    arp_entry_t    mem_q [QUEUE_DEPTH];
    arp_entry_t    mem_d [QUEUE_DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_entry;
            wr_d        = ptr_next(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_next(rd_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge rx_clock) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arp_responder_mc.sv
// ARP responder: validates rx ARP headers, queues replies, reports learned bindings.
// Build option ARP_PAD_EN pads each reply to 48 bytes with trailing zeros.
module arp_responder_mc
    import arp_pkg::*;
#(
    parameter int N_IP        = 2,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               rx_clock,
    input  logic               reset,
    input  logic               rx_enable,
    input  logic [7:0]         rx_data,
    input  logic [47:0]        local_mac,
    input  logic [32*N_IP-1:0] local_ip,
    input  logic [N_IP-1:0]    ip_enable,
    input  logic               tx_enable,
    output logic [7:0]         tx_data,
    output logic               tx_request,
    output logic               tx_active,
    output logic [47:0]        destination_mac,
    output logic               learn_valid,
    output logic [31:0]        learn_ip,
    output logic [47:0]        learn_mac,
    output logic               drop_pulse
);

`ifdef ARP_PAD_EN
    localparam int TX_LEN = ARP_TX_LEN_PAD;
`else
    localparam int TX_LEN = ARP_TX_LEN;
`endif
    localparam logic [5:0] TX_LAST = 6'(TX_LEN - 1);
    localparam logic [4:0] RX_LAST = 5'(ARP_RX_LEN - 1);

    rx_state_e   rx_state_q, rx_state_d;
    logic [4:0]  rx_cnt_q, rx_cnt_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [23:0] tpa_q, tpa_d;
    logic        is_req_q, is_req_d;
    logic        learn_valid_q, learn_valid_d;
    logic [31:0] learn_ip_q, learn_ip_d;
    logic [47:0] learn_mac_q, learn_mac_d;
    logic        drop_q, drop_d;
    logic        sending_q, sending_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;

    logic [4:0]   rx_idx;
    logic         hdr_ok;
    logic         decide;
    logic [31:0]  tpa_full;
    logic         hit;
    logic [1:0]   hit_idx;
    arp_entry_t   push_entry;
    arp_entry_t   head;
    logic         q_push, q_pop, q_full, q_empty;
    logic         tx_start;
    logic [5:0]   tx_idx;
    logic [31:0]  tx_ip;
    logic [239:0] frame;
    logic [239:0] frame_sh;

    // Per-byte check of the fixed header fields; byte 0 arrives in RX_IDLE
    always_comb begin
        rx_idx = (rx_state_q == RX_IDLE) ? 5'd0 : rx_cnt_q;
        hdr_ok = 1'b1;
        unique case (rx_idx)
            5'd0:    hdr_ok = (rx_data == ARP_HTYPE_ETH[15:8]);
            5'd1:    hdr_ok = (rx_data == ARP_HTYPE_ETH[7:0]);
            5'd2:    hdr_ok = (rx_data == ARP_PTYPE_IPV4[15:8]);
            5'd3:    hdr_ok = (rx_data == ARP_PTYPE_IPV4[7:0]);
            5'd4:    hdr_ok = (rx_data == ARP_HLEN);
            5'd5:    hdr_ok = (rx_data == ARP_PLEN);
            5'd6:    hdr_ok = (rx_data == ARP_OPER_REQ[15:8]);
            5'd7:    hdr_ok = (rx_data == ARP_OPER_REQ[7:0]) ||
                              (rx_data == ARP_OPER_REPLY[7:0]);
            default: hdr_ok = 1'b1;
        endcase
    end

    // Lowest enabled, non-zero local address equal to TPA wins
    always_comb begin
        tpa_full = {tpa_q, rx_data};
        hit      = 1'b0;
        hit_idx  = '0;
        for (int k = N_IP - 1; k >= 0; k--) begin
            if (ip_enable[k] && (local_ip[32*k +: 32] != '0) &&
                (local_ip[32*k +: 32] == tpa_full)) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tpa_d      = tpa_q;
        is_req_d   = is_req_q;
        decide     = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_enable) begin
                    rx_cnt_d   = 5'd1;
                    rx_state_d = hdr_ok ? RX_HDR : RX_ERR;
                end
            end
            RX_HDR: begin
                if (!rx_enable) begin
                    rx_state_d = RX_IDLE;
                end else if (!hdr_ok) begin
                    rx_state_d = RX_ERR;
                end else begin
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    if (rx_idx == 5'd7) begin
                        is_req_d = (rx_data == ARP_OPER_REQ[7:0]);
                    end
                    if (rx_idx >= 5'd8 && rx_idx <= 5'd13) begin
                        sha_d = {sha_q[39:0], rx_data};
                    end
                    if (rx_idx >= 5'd14 && rx_idx <= 5'd17) begin
                        spa_d = {spa_q[23:0], rx_data};
                    end
                    if (rx_idx >= 5'd24 && rx_idx <= 5'd26) begin
                        tpa_d = {tpa_q[15:0], rx_data};
                    end
                    if (rx_idx == RX_LAST) begin
                        decide     = 1'b1;
                        rx_state_d = RX_DONE;
                    end
                end
            end
            RX_DONE, RX_ERR: begin
                if (!rx_enable) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        push_entry    = '{mac: sha_q, ip: spa_q, idx: hit_idx};
        q_push        = decide && is_req_q && hit && !q_full;
        drop_d        = decide && is_req_q && hit && q_full;
        learn_valid_d = decide && !is_req_q;
        learn_ip_d    = learn_valid_d ? spa_q : learn_ip_q;
        learn_mac_d   = learn_valid_d ? sha_q : learn_mac_q;
    end

    always_comb begin
        sending_d = sending_q;
        tx_cnt_d  = tx_cnt_q;
        q_pop     = 1'b0;
        tx_start  = tx_enable && tx_request;
        tx_idx    = tx_start ? 6'd0 : tx_cnt_q;
        if (tx_start) begin
            sending_d = 1'b1;
            tx_cnt_d  = 6'd1;
        end else if (sending_q) begin
            if (tx_cnt_q == TX_LAST) begin
                sending_d = 1'b0;
                tx_cnt_d  = '0;
                q_pop     = 1'b1;
            end else begin
                tx_cnt_d = tx_cnt_q + 6'd1;
            end
        end
    end

    // Shifting past the 30-byte body yields the zero pad bytes
    always_comb begin
        tx_ip = '0;
        for (int k = 0; k < N_IP; k++) begin
            if (head.idx == 2'(k)) begin
                tx_ip = local_ip[32*k +: 32];
            end
        end
        frame    = {ARP_REPLY_HDR, local_mac, tx_ip, head.mac, head.ip};
        frame_sh = frame << {tx_idx, 3'b000};
    end

    always_ff @(posedge rx_clock) begin
        if (reset) begin
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            sha_q         <= '0;
            spa_q         <= '0;
            tpa_q         <= '0;
            is_req_q      <= 1'b0;
            learn_valid_q <= 1'b0;
            learn_ip_q    <= '0;
            learn_mac_q   <= '0;
            drop_q        <= 1'b0;
            sending_q     <= 1'b0;
            tx_cnt_q      <= '0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            sha_q         <= sha_d;
            spa_q         <= spa_d;
            tpa_q         <= tpa_d;
            is_req_q      <= is_req_d;
            learn_valid_q <= learn_valid_d;
            learn_ip_q    <= learn_ip_d;
            learn_mac_q   <= learn_mac_d;
            drop_q        <= drop_d;
            sending_q     <= sending_d;
            tx_cnt_q      <= tx_cnt_d;
        end
    end

    arp_reply_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .rx_clock  (rx_clock),
        .reset     (reset),
        .push      (q_push),
        .push_entry(push_entry),
        .pop       (q_pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign tx_request      = !q_empty && !sending_q;
    assign tx_active       = tx_enable || sending_q;
    assign tx_data         = (tx_start || sending_q) ? frame_sh[239:232] : 8'h00;
    assign destination_mac = q_empty ? 48'h0 : head.mac;
    assign learn_valid     = learn_valid_q;
    assign learn_ip        = learn_ip_q;
    assign learn_mac       = learn_mac_q;
    assign drop_pulse      = drop_q;

endmodule

// File: tb/tb_arp_responder_mc.sv
// Directed plus randomized bench for arp_responder_mc against a queue-based reference.
module tb_arp_responder_mc;

    localparam int N_IP = 2;
    localparam int QD   = 2;
`ifdef ARP_PAD_EN
    localparam int FLEN = 48;
`else
    localparam int FLEN = 30;
`endif

    typedef struct {
        logic [47:0] sha;
        logic [31:0] spa;
        int          k;
    } exp_t;

    logic               rx_clock = 1'b0;
    logic               reset = 1'b1;
    logic               rx_enable = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic [47:0]        local_mac;
    logic [31:0]        ips [N_IP];
    logic [32*N_IP-1:0] local_ip;
    logic [N_IP-1:0]    ip_enable = 2'b11;
    logic               tx_enable = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_request;
    logic               tx_active;
    logic [47:0]        destination_mac;
    logic               learn_valid;
    logic [31:0]        learn_ip;
    logic [47:0]        learn_mac;
    logic               drop_pulse;

    int checks = 0;
    int errors = 0;

    logic [15:0] f_htype, f_ptype, f_oper;
    logic [7:0]  f_hlen, f_plen;
    logic [47:0] f_sha, f_tha;
    logic [31:0] f_spa, f_tpa;
    logic [7:0]  frm [$];
    exp_t        mq [$];
    int          drop_cnt, learn_cnt;
    logic        req27;
    logic [31:0] got_lip;
    logic [47:0] got_lmac;
    logic [7:0]  hdr [10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08,
                              8'h00, 8'h06, 8'h04, 8'h00, 8'h02};

    assign local_ip = {ips[1], ips[0]};

    always #5 rx_clock = ~rx_clock;

    arp_responder_mc #(
        .N_IP(N_IP),
        .QUEUE_DEPTH(QD)
    ) dut (
        .rx_clock       (rx_clock),
        .reset          (reset),
        .rx_enable      (rx_enable),
        .rx_data        (rx_data),
        .local_mac      (local_mac),
        .local_ip       (local_ip),
        .ip_enable      (ip_enable),
        .tx_enable      (tx_enable),
        .tx_data        (tx_data),
        .tx_request     (tx_request),
        .tx_active      (tx_active),
        .destination_mac(destination_mac),
        .learn_valid    (learn_valid),
        .learn_ip       (learn_ip),
        .learn_mac      (learn_mac),
        .drop_pulse     (drop_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_match(input logic [31:0] tpa);
        for (int k = 0; k < N_IP; k++) begin
            if (ip_enable[k] && ips[k] != 32'h0 && ips[k] == tpa) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_byte(input int i, input exp_t e);
        if (i < 10) return hdr[i];
        if (i < 16) return 8'(local_mac >> (8 * (15 - i)));
        if (i < 20) return 8'(ips[e.k] >> (8 * (19 - i)));
        if (i < 26) return 8'(e.sha >> (8 * (25 - i)));
        if (i < 30) return 8'(e.spa >> (8 * (29 - i)));
        return 8'h00;
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(8'(v >> (8 * i)));
    endtask

    task automatic set_fields(input logic [15:0] oper, input logic [47:0] sha,
                              input logic [31:0] spa, input logic [31:0] tpa);
        f_htype = 16'h0001;
        f_ptype = 16'h0800;
        f_hlen  = 8'd6;
        f_plen  = 8'd4;
        f_oper  = oper;
        f_sha   = sha;
        f_spa   = spa;
        f_tha   = {16'($urandom), $urandom};
        f_tpa   = tpa;
    endtask

    task automatic mk_frame();
        frm = {};
        push_be(64'(f_htype), 2);
        push_be(64'(f_ptype), 2);
        push_be(64'(f_hlen), 1);
        push_be(64'(f_plen), 1);
        push_be(64'(f_oper), 2);
        push_be(64'(f_sha), 6);
        push_be(64'(f_spa), 4);
        push_be(64'(f_tha), 6);
        push_be(64'(f_tpa), 4);
    endtask

    task automatic sample_pulses();
        drop_cnt  += int'(drop_pulse);
        learn_cnt += int'(learn_valid);
        if (learn_valid === 1'b1) begin
            got_lip  = learn_ip;
            got_lmac = learn_mac;
        end
    endtask

    task automatic send(input int nb, input int pad);
        drop_cnt  = 0;
        learn_cnt = 0;
        req27     = 1'b0;
        got_lip   = 'x;
        got_lmac  = 'x;
        mk_frame();
        for (int i = 0; i < nb + pad; i++) begin
            @(negedge rx_clock);
            sample_pulses();
            if (i == 27) req27 = tx_request;
            rx_enable = 1'b1;
            rx_data   = (i < nb) ? frm[i] : 8'($urandom);
        end
        @(negedge rx_clock);
        sample_pulses();
        rx_enable = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic model_rx(input int nb, input string tag);
        int   k;
        bit   ok;
        int   exp_drop;
        int   exp_learn;
        exp_t e;
        exp_drop  = 0;
        exp_learn = 0;
        ok = (nb >= 28) && f_htype == 16'h0001 && f_ptype == 16'h0800 &&
             f_hlen == 8'd6 && f_plen == 8'd4 && (f_oper == 16'd1 || f_oper == 16'd2);
        if (ok && f_oper == 16'd1) begin
            k = ref_match(f_tpa);
            if (k >= 0) begin
                if (mq.size() < QD) begin
                    e = '{f_sha, f_spa, k};
                    mq.push_back(e);
                end else begin
                    exp_drop = 1;
                end
            end
        end
        if (ok && f_oper == 16'd2) exp_learn = 1;
        check({tag, " drop"}, 64'(drop_cnt), 64'(exp_drop));
        check({tag, " learn"}, 64'(learn_cnt), 64'(exp_learn));
        if (exp_learn == 1) begin
            check({tag, " lip"}, 64'(got_lip), 64'(f_spa));
            check({tag, " lmac"}, 64'(got_lmac), 64'(f_sha));
        end
        check({tag, " req"}, 64'(tx_request), 64'(mq.size() != 0));
    endtask

    task automatic grant(input string tag);
        exp_t       e;
        logic [7:0] got [64];
        int         n;
        n = 0;
        e = mq.pop_front();
        @(negedge rx_clock);
        check({tag, " req"}, 64'(tx_request), 64'd1);
        tx_enable = 1'b1;
        #1;
        check({tag, " dmac"}, 64'(destination_mac), 64'(e.sha));
        while (tx_active === 1'b1 && n < 64) begin
            got[n] = tx_data;
            n++;
            @(negedge rx_clock);
            tx_enable = 1'b0;
            #1;
        end
        tx_enable = 1'b0;
        check({tag, " len"}, 64'(n), 64'(FLEN));
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("%s b%0d", tag, i), 64'(got[i]), 64'(ref_byte(i, e)));
        end
    endtask

    task automatic grant_empty();
        @(negedge rx_clock);
        check("empty req", 64'(tx_request), 64'd0);
        tx_enable = 1'b1;
        #1;
        check("empty act", 64'(tx_active), 64'd1);
        check("empty data", 64'(tx_data), 64'd0);
        @(negedge rx_clock);
        tx_enable = 1'b0;
        #1;
        check("empty act end", 64'(tx_active), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   r;
        local_mac = {16'($urandom), $urandom};
        ips[0]    = 32'hC0A8010A;
        ips[1]    = 32'hC0A80114;

        repeat (3) @(negedge rx_clock);
        #1;
        check("rst tx_request", 64'(tx_request), 64'd0);
        check("rst tx_active", 64'(tx_active), 64'd0);
        check("rst learn_valid", 64'(learn_valid), 64'd0);
        check("rst drop", 64'(drop_pulse), 64'd0);
        check("rst dmac", 64'(destination_mac), 64'd0);
        check("rst tx_data", 64'(tx_data), 64'd0);
        check("rst learn_ip", 64'(learn_ip), 64'd0);
        check("rst learn_mac", 64'(learn_mac), 64'd0);
        reset = 1'b0;

        set_fields(16'd1, 48'h001122334455, 32'hC0A80105, 32'hC0A80114);
        send(28, 0);
        check("t1 req before", 64'(req27), 64'd0);
        model_rx(28, "t1");
        check("t1 dmac", 64'(destination_mac), 64'h001122334455);
        grant("t1");
        check("t1 req after", 64'(tx_request), 64'd0);

        ip_enable = 2'b01;
        send(28, 0);
        model_rx(28, "t2 disabled");
        ip_enable = 2'b11;
        f_ptype = 16'h86DD;
        send(28, 0);
        model_rx(28, "t2 ptype");
        ips[0] = 32'h0;
        set_fields(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80107, 32'h0);
        send(28, 0);
        model_rx(28, "t2 zero ip");
        ips[0] = 32'hC0A8010A;

        for (int i = 0; i < 3; i++) begin
            set_fields(16'd1, {16'($urandom), $urandom}, $urandom, ips[$urandom_range(0, 1)]);
            send(28, 0);
            model_rx(28, $sformatf("t3 req%0d", i));
        end
        grant("t3 g0");
        grant("t3 g1");
        grant_empty();

        set_fields(16'd2, 48'h020000000009, 32'h0A000009, 32'hC0A80114);
        send(28, 0);
        model_rx(28, "t4");
        @(negedge rx_clock);
        check("t4 pulse end", 64'(learn_valid), 64'd0);
        check("t4 lip held", 64'(learn_ip), 64'h0A000009);
        check("t4 lmac held", 64'(learn_mac), 64'h020000000009);

        set_fields(16'd1, 48'h001122334455, 32'hC0A80105, 32'hC0A80114);
        send(20, 0);
        model_rx(20, "t5 runt");

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            set_fields(($urandom_range(0, 3) == 0) ? 16'd2 : 16'd1,
                       {16'($urandom), $urandom}, $urandom,
                       (r < 2) ? ips[r] : $urandom);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 4))
                    0:       f_htype = 16'($urandom);
                    1:       f_ptype = 16'h86DD;
                    2:       f_hlen  = 8'($urandom_range(0, 5));
                    3:       f_plen  = 8'h06;
                    default: f_oper  = 16'($urandom_range(0, 4));
                endcase
            end
            ip_enable = 2'($urandom_range(0, 3));
            send(28, $urandom_range(0, 5));
            model_rx(28, $sformatf("rnd%0d", it));
            if (mq.size() != 0 && $urandom_range(0, 1) == 1) begin
                grant($sformatf("rnd%0d g", it));
            end
        end
        ip_enable = 2'b11;
        while (mq.size() != 0) grant("drain");

        set_fields(16'd1, {16'($urandom), $urandom}, $urandom, ips[1]);
        send(28, 0);
        model_rx(28, "t6");
        e = mq.pop_front();
        @(negedge rx_clock);
        tx_enable = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            @(negedge rx_clock);
            tx_enable = 1'b0;
            #1;
        end
        check("t6 b12", 64'(tx_data), 64'(ref_byte(12, e)));
        reset = 1'b1;
        @(negedge rx_clock);
        #1;
        check("t6 act after rst", 64'(tx_active), 64'd0);
        check("t6 req after rst", 64'(tx_request), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge rx_clock);
        #1;
        check("t6 act later", 64'(tx_active), 64'd0);
        check("t6 req later", 64'(tx_request), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
